// File: rtl/gobou_fc_ctrl_if.sv
// ============================================================================
// Module  : gobou_fc_ctrl_if
// Brief   : Host/core-array bundle for the gobou FC control core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface gobou_fc_ctrl_if #(
  parameter int CORE    = 16,
  parameter int CORELOG = 4,
  parameter int DWIDTH  = 16,
  parameter int LWIDTH  = 12,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 14
);
  logic                 req;
  logic                 bias_en;
  logic [LWIDTH-1:0]    total_in;
  logic [LWIDTH-1:0]    total_out;
  logic [IMGSIZE-1:0]   input_addr;
  logic [IMGSIZE-1:0]   output_addr;
  logic [NETSIZE-1:0]   net_addr;
  logic                 img_we;
  logic [DWIDTH-1:0]    write_img;
  logic [CORELOG:0]     net_we;
  logic                 in_begin;
  logic [DWIDTH-1:0]    write_result;

  logic                 ack;
  logic                 out_begin;
  logic                 out_valid;
  logic                 out_end;
  logic                 mem_img_we;
  logic [IMGSIZE-1:0]   mem_img_addr;
  logic [DWIDTH-1:0]    write_mem_img;
  logic [CORE-1:0]      mem_net_we;
  logic [NETSIZE-1:0]   mem_net_addr;
  logic                 breg_we;
  logic                 serial_we;

  modport master (
    output req, bias_en, total_in, total_out, input_addr, output_addr,
           net_addr, img_we, write_img, net_we, in_begin, write_result,
    input  ack, out_begin, out_valid, out_end, mem_img_we, mem_img_addr,
           write_mem_img, mem_net_we, mem_net_addr, breg_we, serial_we
  );

  modport slave (
    input  req, bias_en, total_in, total_out, input_addr, output_addr,
           net_addr, img_we, write_img, net_we, in_begin, write_result,
    output ack, out_begin, out_valid, out_end, mem_img_we, mem_img_addr,
           write_mem_img, mem_net_we, mem_net_addr, breg_we, serial_we
  );
endinterface

`default_nettype wire

// File: rtl/gobou_fc_ctrl.sv
// ============================================================================
// Module  : gobou_fc_ctrl
// Brief   : Weight/bias fetch and result write-back sequencer for CORE MACs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gobou_fc_ctrl #(
  parameter int CORE    = 16,
  parameter int CORELOG = 4,
  parameter int DWIDTH  = 16,
  parameter int LWIDTH  = 12,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 14
) (
  input  logic           clk,
  input  logic           xrst,
  gobou_fc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WEIGHT = 2'd1,
    S_BIAS   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [CORELOG:0] c_ser_end = (CORELOG+1)'(CORE + 1);
  localparam logic [LWIDTH:0]  c_core_l  = (LWIDTH+1)'(CORE);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [LWIDTH-1:0]    r_total_in;
  logic [LWIDTH-1:0]    r_total_out;
  logic                 r_bias_en;
  logic [IMGSIZE-1:0]   r_in_base;
  logic [IMGSIZE-1:0]   r_out_base;
  logic [NETSIZE-1:0]   r_net_base;

  logic [LWIDTH-1:0]    r_cnt_in;
  logic [LWIDTH-1:0]    r_cnt_out;
  logic [NETSIZE-1:0]   r_net_ptr;
  logic [IMGSIZE-1:0]   r_out_ptr;
  logic [CORELOG:0]     r_ser_cnt;

  logic                 r_out_begin;
  logic                 r_out_valid;
  logic                 r_out_end;
  logic                 r_mem_img_we;
  logic [IMGSIZE-1:0]   r_mem_img_addr;
  logic [DWIDTH-1:0]    r_write_mem_img;
  logic [CORE-1:0]      r_mem_net_we;
  logic [NETSIZE-1:0]   r_mem_net_addr;
  logic                 r_breg_we;
  logic                 r_serial_we;

  logic                 w_start;
  logic                 w_wt_last;
  logic                 w_grp_end;
  logic                 w_last_grp;
  logic [LWIDTH:0]      w_remain;
  logic [LWIDTH:0]      w_valid;
  logic                 w_slot_wr;
  logic [CORE-1:0]      w_net_dec;

  assign w_start   = (r_state == S_IDLE) && bus.req &&
                     (bus.total_in != '0) && (bus.total_out != '0);
  assign w_wt_last = (r_cnt_in == (r_total_in - LWIDTH'(1)));
  assign w_grp_end = (r_ser_cnt == c_ser_end);

  // Group arithmetic is one bit wider so cnt_out + CORE cannot wrap.
  assign w_last_grp = (({1'b0, r_cnt_out} + c_core_l) >= {1'b0, r_total_out});
  assign w_remain   = {1'b0, r_total_out} - {1'b0, r_cnt_out};
  assign w_valid    = w_last_grp ? w_remain : c_core_l;
  assign w_slot_wr  = ((LWIDTH+1)'(r_ser_cnt) <= w_valid);

  always_comb begin
    w_net_dec = '0;
    for (int k = 0; k < CORE; k++) begin
      w_net_dec[k] = (int'(bus.net_we) == k + 1);
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_WEIGHT;
      S_WEIGHT: if (w_wt_last) w_state_nxt = r_bias_en ? S_BIAS : S_OUTPUT;
      S_BIAS:   w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (w_grp_end) w_state_nxt = w_last_grp ? S_IDLE : S_WEIGHT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_total_in      <= '0;
      r_total_out     <= '0;
      r_bias_en       <= 1'b0;
      r_in_base       <= '0;
      r_out_base      <= '0;
      r_net_base      <= '0;
      r_cnt_in        <= '0;
      r_cnt_out       <= '0;
      r_net_ptr       <= '0;
      r_out_ptr       <= '0;
      r_ser_cnt       <= '0;
      r_out_begin     <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_end       <= 1'b0;
      r_mem_img_we    <= 1'b0;
      r_mem_img_addr  <= '0;
      r_write_mem_img <= '0;
      r_mem_net_we    <= '0;
      r_mem_net_addr  <= '0;
      r_breg_we       <= 1'b0;
      r_serial_we     <= 1'b0;
    end else begin
      r_out_begin  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_end    <= 1'b0;
      r_breg_we    <= 1'b0;
      r_serial_we  <= 1'b0;
      r_mem_img_we <= 1'b0;
      r_mem_net_we <= '0;
      case (r_state)
        S_IDLE: begin
          r_mem_img_we    <= bus.img_we;
          r_mem_img_addr  <= bus.input_addr;
          r_write_mem_img <= bus.write_img;
          r_mem_net_we    <= w_net_dec;
          r_mem_net_addr  <= bus.net_addr;
          if (w_start) begin
            r_total_in  <= bus.total_in;
            r_total_out <= bus.total_out;
            r_bias_en   <= bus.bias_en;
            r_in_base   <= bus.input_addr;
            r_out_base  <= bus.output_addr;
            r_net_base  <= bus.net_addr;
            r_cnt_in    <= '0;
            r_out_begin <= 1'b1;
          end
        end
        S_WEIGHT: begin
          r_mem_img_addr <= r_in_base + IMGSIZE'(r_cnt_in);
          r_mem_net_addr <= r_net_base + r_net_ptr;
          r_net_ptr      <= r_net_ptr + NETSIZE'(1);
          r_out_valid    <= 1'b1;
          if (w_wt_last) begin
            r_cnt_in  <= '0;
            r_out_end <= !r_bias_en;
          end else begin
            r_cnt_in  <= r_cnt_in + LWIDTH'(1);
          end
        end
        S_BIAS: begin
          r_mem_net_addr <= r_net_base + r_net_ptr;
          r_net_ptr      <= r_net_ptr + NETSIZE'(1);
          r_out_valid    <= 1'b1;
          r_out_end      <= 1'b1;
          r_breg_we      <= 1'b1;
        end
        S_OUTPUT: begin
          // r_ser_cnt: 0 waits for in_begin, 1..CORE are result slots, CORE+1 ends the group.
          if (r_ser_cnt == '0) begin
            if (bus.in_begin) begin
              r_serial_we <= 1'b1;
              r_ser_cnt   <= (CORELOG+1)'(1);
            end
          end else if (w_grp_end) begin
            r_ser_cnt <= '0;
            if (w_last_grp) begin
              r_cnt_out <= '0;
              r_net_ptr <= '0;
              r_out_ptr <= '0;
            end else begin
              r_cnt_out   <= r_cnt_out + LWIDTH'(CORE);
              r_out_begin <= 1'b1;
            end
          end else begin
            r_ser_cnt <= r_ser_cnt + (CORELOG+1)'(1);
            if (w_slot_wr) begin
              r_mem_img_we    <= 1'b1;
              r_mem_img_addr  <= r_out_base + r_out_ptr;
              r_write_mem_img <= bus.write_result;
              r_out_ptr       <= r_out_ptr + IMGSIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack           = (r_state == S_IDLE);
  assign bus.out_begin     = r_out_begin;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_end       = r_out_end;
  assign bus.mem_img_we    = r_mem_img_we;
  assign bus.mem_img_addr  = r_mem_img_addr;
  assign bus.write_mem_img = r_write_mem_img;
  assign bus.mem_net_we    = r_mem_net_we;
  assign bus.mem_net_addr  = r_mem_net_addr;
  assign bus.breg_we       = r_breg_we;
  assign bus.serial_we     = r_serial_we;

endmodule

`default_nettype wire

// File: tb/tb_gobou_fc_ctrl.sv
// ============================================================================
// Module  : tb_gobou_fc_ctrl
// Brief   : Directed bench for gobou_fc_ctrl (CORE=16 and CORE=8 builds).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gobou_fc_ctrl;

  logic clk;
  logic xrst;

  gobou_fc_ctrl_if #(.CORE(16), .CORELOG(4)) h ();
  gobou_fc_ctrl_if #(.CORE(8),  .CORELOG(3)) h8 ();

  gobou_fc_ctrl #(.CORE(16), .CORELOG(4)) u_dut16 (
    .clk  (clk),
    .xrst (xrst),
    .bus  (h.slave)
  );

  gobou_fc_ctrl #(.CORE(8), .CORELOG(3)) u_dut8 (
    .clk  (clk),
    .xrst (xrst),
    .bus  (h8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        img_we;
    logic [11:0] in_addr;
    logic [15:0] wimg;
    logic [4:0]  net_we;
    logic [13:0] net_addr;
    logic        e_img_we;
    logic [11:0] e_img_addr;
    logic [15:0] e_wimg;
    logic [15:0] e_net_we;
    logic [13:0] e_net_addr;
  } host_vec_t;

  host_vec_t vecs[6];

  // Observation log, cleared at the start of each job.
  logic [13:0] net_q[$];
  logic [11:0] img_q[$];
  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];
  int n_oe, n_breg, n_sw, n_ob, n_netwe;
  logic mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      net_q.delete(); img_q.delete(); wa_q.delete(); wd_q.delete();
      n_oe = 0; n_breg = 0; n_sw = 0; n_ob = 0; n_netwe = 0;
    end else begin
      if (h.out_valid) begin
        net_q.push_back(h.mem_net_addr);
        if (!h.breg_we) img_q.push_back(h.mem_img_addr);
      end
      if (h.mem_img_we) begin
        wa_q.push_back(h.mem_img_addr);
        wd_q.push_back(h.write_mem_img);
      end
      if (h.out_end)   n_oe++;
      if (h.breg_we)   n_breg++;
      if (h.serial_we) n_sw++;
      if (h.out_begin) n_ob++;
      if (h.mem_net_we != '0) n_netwe++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_job(input int tin, input int tout, input bit bias,
                        input logic [11:0] ib, input logic [11:0] ob,
                        input logic [13:0] nb, input bit disturb);
    int ng;
    int t;
    int per;
    mon_clr       = 1'b1;
    h.req         = 1'b1;
    h.bias_en     = bias;
    h.total_in    = 12'(tin);
    h.total_out   = 12'(tout);
    h.input_addr  = ib;
    h.output_addr = ob;
    h.net_addr    = nb;
    tick();
    mon_clr = 1'b0;
    h.req   = 1'b0;
    check("ack_low_at_start", h.ack, 0);
    check("out_begin_at_start", h.out_begin, 1);
    ng = (tout + 15) / 16;
    for (int g = 0; g < ng; g++) begin
      if (disturb && g == 1) begin
        h.req = 1'b1; h.in_begin = 1'b1; h.total_in = 12'd1;
        h.img_we = 1'b1; h.net_we = 5'd2;
        tick();
        h.req = 1'b0; h.in_begin = 1'b0; h.img_we = 1'b0; h.net_we = 5'd0;
        check("in_begin_ignored_in_weight", h.serial_we, 0);
        check("host_we_ignored_in_weight", h.mem_img_we, 0);
      end
      t = 0;
      while (!h.out_end && t < 200) begin
        tick();
        t++;
      end
      check("out_end_wait", h.out_end, 1);
      h.in_begin = 1'b1;
      tick();
      h.in_begin = 1'b0;
      check("serial_we_at_T", h.serial_we, 1);
      for (int j = 0; j < 16; j++) begin
        h.write_result = 16'(32'hA000 + g * 256 + j);
        tick();
      end
      check("ack_low_at_group_end", h.ack, 0);
      tick();
      if (g == ng - 1) check("ack_after_last_group", h.ack, 1);
      else             check("out_begin_next_group", h.out_begin, 1);
    end
    per = tin + (bias ? 1 : 0);
    check("net_addr_count", net_q.size(), ng * per);
    for (int k = 0; k < net_q.size() && k < ng * per; k++)
      check("net_addr_seq", net_q[k], 32'(nb) + k);
    check("img_rd_count", img_q.size(), ng * tin);
    for (int k = 0; k < img_q.size() && k < ng * tin; k++)
      check("img_rd_addr", img_q[k], 32'(ib) + (k % tin));
    check("write_count", wa_q.size(), tout);
    for (int k = 0; k < wa_q.size() && k < tout; k++) begin
      check("write_addr", wa_q[k], 32'(ob) + k);
      check("write_data", wd_q[k], 32'hA000 + (k / 16) * 256 + (k % 16));
    end
    check("out_end_count", n_oe, ng);
    check("breg_we_count", n_breg, bias ? ng : 0);
    check("serial_we_count", n_sw, ng);
    check("out_begin_count", n_ob, ng);
    check("net_we_in_run", n_netwe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 12'h000, 16'h0000, 5'd3,  14'h0005, 1'b0, 12'h000, 16'h0000, 16'h0004, 14'h0005};
    vecs[1] = '{1'b0, 12'h000, 16'h0000, 5'd17, 14'h0009, 1'b0, 12'h000, 16'h0000, 16'h0000, 14'h0009};
    vecs[2] = '{1'b1, 12'h123, 16'hBEEF, 5'd1,  14'h3FFF, 1'b1, 12'h123, 16'hBEEF, 16'h0001, 14'h3FFF};
    vecs[3] = '{1'b1, 12'hFFF, 16'h8000, 5'd16, 14'h0010, 1'b1, 12'hFFF, 16'h8000, 16'h8000, 14'h0010};
    vecs[4] = '{1'b0, 12'h055, 16'h1234, 5'd31, 14'h0000, 1'b0, 12'h055, 16'h1234, 16'h0000, 14'h0000};
    vecs[5] = '{1'b0, 12'h000, 16'h0000, 5'd0,  14'h0000, 1'b0, 12'h000, 16'h0000, 16'h0000, 14'h0000};

    xrst = 1'b0;
    h.req = 0; h.bias_en = 0; h.total_in = 0; h.total_out = 0;
    h.input_addr = 0; h.output_addr = 0; h.net_addr = 0; h.img_we = 0;
    h.write_img = 0; h.net_we = 0; h.in_begin = 0; h.write_result = 0;
    h8.req = 0; h8.bias_en = 0; h8.total_in = 0; h8.total_out = 0;
    h8.input_addr = 0; h8.output_addr = 0; h8.net_addr = 0; h8.img_we = 0;
    h8.write_img = 0; h8.net_we = 0; h8.in_begin = 0; h8.write_result = 0;
    tick(); tick();
    check("reset_ack", h.ack, 1);
    check("reset_out_begin", h.out_begin, 0);
    check("reset_mem_img_we", h.mem_img_we, 0);
    check("reset_mem_net_we", h.mem_net_we, 0);
    check("reset_serial_we", h.serial_we, 0);
    xrst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      h.img_we = vecs[i].img_we; h.input_addr = vecs[i].in_addr;
      h.write_img = vecs[i].wimg; h.net_we = vecs[i].net_we;
      h.net_addr = vecs[i].net_addr;
      tick();
      check("host_mem_img_we", h.mem_img_we, vecs[i].e_img_we);
      check("host_mem_img_addr", h.mem_img_addr, vecs[i].e_img_addr);
      check("host_write_mem_img", h.write_mem_img, vecs[i].e_wimg);
      check("host_mem_net_we", h.mem_net_we, vecs[i].e_net_we);
      check("host_mem_net_addr", h.mem_net_addr, vecs[i].e_net_addr);
    end
    h.img_we = 0; h.net_we = 0; h.input_addr = 0; h.write_img = 0; h.net_addr = 0;

    h.req = 1'b1; h.total_in = 12'd0; h.total_out = 12'd5;
    tick();
    check("zero_total_in_ack", h.ack, 1);
    check("zero_total_in_begin", h.out_begin, 0);
    h.total_in = 12'd3; h.total_out = 12'd0;
    tick();
    check("zero_total_out_ack", h.ack, 1);
    h.req = 1'b0;
    tick();

    // Abort a run mid-WEIGHT with the asynchronous reset.
    h.req = 1'b1; h.total_in = 12'd8; h.total_out = 12'd16; h.net_addr = 14'h0033;
    tick();
    h.req = 1'b0;
    tick(); tick();
    check("weight_out_valid", h.out_valid, 1);
    #2 xrst = 1'b0;
    #1;
    check("async_reset_ack", h.ack, 1);
    check("async_reset_out_valid", h.out_valid, 0);
    check("async_reset_net_addr", h.mem_net_addr, 0);
    check("async_reset_img_addr", h.mem_img_addr, 0);
    tick();
    xrst = 1'b1;
    tick();

    do_job(4, 16, 1'b1, 12'h100, 12'h200, 14'h0000, 1'b0);
    tick();
    do_job(4, 20, 1'b0, 12'h040, 12'h300, 14'h0020, 1'b1);
    tick();

    h8.req = 1'b1; h8.total_in = 12'd1; h8.total_out = 12'd8; h8.output_addr = 12'h0A0;
    tick();
    h8.req = 1'b0;
    check("c8_out_begin", h8.out_begin, 1);
    tick();
    check("c8_out_end", h8.out_end, 1);
    check("c8_out_valid", h8.out_valid, 1);
    h8.in_begin = 1'b1;
    tick();
    h8.in_begin = 1'b0;
    check("c8_serial_we", h8.serial_we, 1);
    h8.write_result = 16'h5A5A;
    tick();
    check("c8_first_write_we", h8.mem_img_we, 1);
    check("c8_first_write_addr", h8.mem_img_addr, 12'h0A0);
    check("c8_first_write_data", h8.write_mem_img, 16'h5A5A);
    for (int j = 0; j < 7; j++) tick();
    check("c8_ack_at_group_end", h8.ack, 0);
    tick();
    check("c8_ack_after_group", h8.ack, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
